// File: rtl/sp_ram_fill_engine_if.sv
// Single-port data RAM port as driven by sp_ram_fill_engine (master) and served by the RAM (slave).
// Tag sideband exists only when SP_RAM_FILL_TAG_EN is defined.
interface sp_ram_fill_engine_if #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  ram_en_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [DATA_WIDTH-1:0] ram_wdata_o;
  logic                  ram_we_o;
  logic [BE_WIDTH-1:0]   ram_be_o;
  logic [DATA_WIDTH-1:0] ram_rdata_i;
`ifdef SP_RAM_FILL_TAG_EN
  logic                  ram_we_tag_o;
  logic                  ram_wdata_tag_o;
  logic [BE_WIDTH-1:0]   ram_rdata_tag_i;
`endif

  modport master (
    output ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o,
`ifdef SP_RAM_FILL_TAG_EN
    output ram_we_tag_o, ram_wdata_tag_o,
    input  ram_rdata_tag_i,
`endif
    input  ram_rdata_i
  );

  modport slave (
    input  ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o,
`ifdef SP_RAM_FILL_TAG_EN
    input  ram_we_tag_o, ram_wdata_tag_o,
    output ram_rdata_tag_i,
`endif
    output ram_rdata_i
  );
endinterface

// File: rtl/sp_ram_fill_engine.sv
// Fills a word-aligned RAM region with a constant/incrementing pattern and optionally reads it back.
// Optional DIFT tag write/check is enabled by defining SP_RAM_FILL_TAG_EN.
module sp_ram_fill_engine #(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  verify_i,
  input  logic                  incr_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-2:0] num_words_i,
  input  logic [DATA_WIDTH-1:0] pattern_i,
`ifdef SP_RAM_FILL_TAG_EN
  input  logic                  tag_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  sp_ram_fill_engine_if.master  ram
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = ADDR_WIDTH - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_VERIFY,
    ST_VDRAIN,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [DATA_WIDTH-1:0] pat_q, pat_d;
  logic                  incr_q, incr_d;
  logic                  verify_q, verify_d;
  logic                  tag_q, tag_d;
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [BE_WIDTH-1:0]   ram_be_q, ram_be_d;
  logic                  ram_we_tag_q, ram_we_tag_d;
  logic                  ram_wdata_tag_q, ram_wdata_tag_d;

  // Read-back compare stage, one cycle behind the read it belongs to
  logic                  cmp_vld_q, cmp_vld_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic [DATA_WIDTH-1:0] cmp_data_q, cmp_data_d;

  logic                  tag_in_c;
  logic                  tag_bad_c;
  logic                  last_c;
  logic [DATA_WIDTH-1:0] step_c;
  logic [ADDR_WIDTH-1:0] base_in_c;
  logic [1:0]            unused_base_c;

  assign unused_base_c = base_addr_i[1:0];
  assign base_in_c     = {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign last_c        = (idx_q == (num_q - CNT_WIDTH'(1)));
  assign step_c        = DATA_WIDTH'(incr_q);

`ifdef SP_RAM_FILL_TAG_EN
  assign tag_in_c  = tag_i;
  assign tag_bad_c = (ram.ram_rdata_tag_i != {BE_WIDTH{tag_q}});
  assign ram.ram_we_tag_o    = ram_we_tag_q;
  assign ram.ram_wdata_tag_o = ram_wdata_tag_q;
`else
  assign tag_in_c  = 1'b0;
  assign tag_bad_c = 1'b0;
  logic unused_tag_c;
  assign unused_tag_c = ^{tag_q, ram_we_tag_q, ram_wdata_tag_q};
`endif

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    num_d           = num_q;
    pat_d           = pat_q;
    incr_d          = incr_q;
    verify_d        = verify_q;
    tag_d           = tag_q;
    idx_d           = idx_q;
    cur_d           = cur_q;
    busy_d          = 1'b0;
    done_d          = 1'b0;
    error_d         = error_q;
    err_addr_d      = err_addr_q;
    ram_en_d        = 1'b0;
    ram_we_d        = 1'b0;
    ram_addr_d      = '0;
    ram_wdata_d     = '0;
    ram_be_d        = '0;
    ram_we_tag_d    = 1'b0;
    ram_wdata_tag_d = 1'b0;
    cmp_vld_d       = 1'b0;
    cmp_addr_d      = cmp_addr_q;
    cmp_data_d      = cmp_data_q;

    // Sticky error; only the first mismatching address is kept
    if (cmp_vld_q && ((ram.ram_rdata_i != cmp_data_q) || tag_bad_c)) begin
      error_d = 1'b1;
      if (!error_q) begin
        err_addr_d = cmp_addr_q;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d     = base_in_c;
          num_d      = num_words_i;
          pat_d      = pattern_i;
          incr_d     = incr_i;
          verify_d   = verify_i;
          tag_d      = tag_in_c;
          error_d    = 1'b0;
          err_addr_d = '0;
          busy_d     = 1'b1;
          if (num_words_i == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d         = ST_FILL;
            idx_d           = '0;
            cur_d           = pattern_i;
            ram_en_d        = 1'b1;
            ram_we_d        = 1'b1;
            ram_be_d        = '1;
            ram_addr_d      = base_in_c;
            ram_wdata_d     = pattern_i;
            ram_we_tag_d    = 1'b1;
            ram_wdata_tag_d = tag_in_c;
          end
        end
      end

      ST_FILL: begin
        busy_d = 1'b1;
        if (last_c) begin
          if (verify_q) begin
            state_d    = ST_VERIFY;
            idx_d      = '0;
            cur_d      = pat_q;
            ram_en_d   = 1'b1;
            ram_be_d   = '1;
            ram_addr_d = base_q;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          idx_d           = idx_q + CNT_WIDTH'(1);
          cur_d           = cur_q + step_c;
          ram_en_d        = 1'b1;
          ram_we_d        = 1'b1;
          ram_be_d        = '1;
          ram_addr_d      = ram_addr_q + ADDR_WIDTH'(4);
          ram_wdata_d     = cur_q + step_c;
          ram_we_tag_d    = 1'b1;
          ram_wdata_tag_d = tag_q;
        end
      end

      ST_VERIFY: begin
        busy_d     = 1'b1;
        cmp_vld_d  = 1'b1;
        cmp_addr_d = ram_addr_q;
        cmp_data_d = cur_q;
        if (last_c) begin
          state_d = ST_VDRAIN;
        end else begin
          idx_d      = idx_q + CNT_WIDTH'(1);
          cur_d      = cur_q + step_c;
          ram_en_d   = 1'b1;
          ram_be_d   = '1;
          ram_addr_d = ram_addr_q + ADDR_WIDTH'(4);
        end
      end

      ST_VDRAIN: begin
        busy_d  = 1'b1;
        state_d = ST_DONE;
        done_d  = 1'b1;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      base_q          <= '0;
      num_q           <= '0;
      pat_q           <= '0;
      incr_q          <= 1'b0;
      verify_q        <= 1'b0;
      tag_q           <= 1'b0;
      idx_q           <= '0;
      cur_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      err_addr_q      <= '0;
      ram_en_q        <= 1'b0;
      ram_we_q        <= 1'b0;
      ram_addr_q      <= '0;
      ram_wdata_q     <= '0;
      ram_be_q        <= '0;
      ram_we_tag_q    <= 1'b0;
      ram_wdata_tag_q <= 1'b0;
      cmp_vld_q       <= 1'b0;
      cmp_addr_q      <= '0;
      cmp_data_q      <= '0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      num_q           <= num_d;
      pat_q           <= pat_d;
      incr_q          <= incr_d;
      verify_q        <= verify_d;
      tag_q           <= tag_d;
      idx_q           <= idx_d;
      cur_q           <= cur_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
      err_addr_q      <= err_addr_d;
      ram_en_q        <= ram_en_d;
      ram_we_q        <= ram_we_d;
      ram_addr_q      <= ram_addr_d;
      ram_wdata_q     <= ram_wdata_d;
      ram_be_q        <= ram_be_d;
      ram_we_tag_q    <= ram_we_tag_d;
      ram_wdata_tag_q <= ram_wdata_tag_d;
      cmp_vld_q       <= cmp_vld_d;
      cmp_addr_q      <= cmp_addr_d;
      cmp_data_q      <= cmp_data_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign error_o         = error_q;
  assign err_addr_o      = err_addr_q;
  assign ram.ram_en_o    = ram_en_q;
  assign ram.ram_we_o    = ram_we_q;
  assign ram.ram_addr_o  = ram_addr_q;
  assign ram.ram_wdata_o = ram_wdata_q;
  assign ram.ram_be_o    = ram_be_q;

endmodule

// File: tb/tb_sp_ram_fill_engine.sv
// Scoreboard bench for sp_ram_fill_engine: a behavioural RAM plus a reference model of the
// expected access stream and completion status, checked by an independent monitor.
module tb_sp_ram_fill_engine;

  localparam int unsigned AW     = 15;
  localparam int unsigned DW     = 32;
  localparam int unsigned NWORDS = 8192;

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  typedef struct {
    int            cyc;
    logic          err;
    logic [AW-1:0] ea;
    bit            ea_chk;
  } done_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          verify_i = 1'b0;
  logic          incr_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW-2:0] num_words_i = '0;
  logic [DW-1:0] pattern_i = '0;
  logic          busy_o, done_o, error_o;
  logic [AW-1:0] err_addr_o;
`ifdef SP_RAM_FILL_TAG_EN
  logic          tag_i = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  acc_t  exp_acc[$];
  done_t exp_done[$];
  int    cor_q[$];

  logic [DW-1:0] mem [NWORDS];
  bit            corrupt [NWORDS];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sp_ram_fill_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sp_ram_fill_engine #(.RAM_SIZE(32768), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .verify_i   (verify_i),
    .incr_i     (incr_i),
    .base_addr_i(base_addr_i),
    .num_words_i(num_words_i),
    .pattern_i  (pattern_i),
`ifdef SP_RAM_FILL_TAG_EN
    .tag_i      (tag_i),
`endif
    .busy_o     (busy_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .err_addr_o (err_addr_o),
    .ram        (bus)
  );

`ifdef SP_RAM_FILL_TAG_EN
  assign bus.ram_rdata_tag_i = {4{tag_i}};
`endif

  // Behavioural RAM; flagged words read back with one bit flipped
  always @(posedge clk) begin
    if (rst_i) begin
      bus.ram_rdata_i <= '0;
    end else if (bus.ram_en_o) begin
      if (bus.ram_we_o) mem[bus.ram_addr_o[AW-1:2]] <= bus.ram_wdata_o;
      else bus.ram_rdata_i <= mem[bus.ram_addr_o[AW-1:2]] ^
                              (corrupt[bus.ram_addr_o[AW-1:2]] ? 32'h0000_0100 : 32'h0);
    end
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents an access or a completion
  always @(negedge clk) begin
    if (!rst_i) begin
      if (bus.ram_en_o) begin
        if (exp_acc.size() == 0) begin
          chk("ram_en_unexpected", 64'(bus.ram_en_o), 64'd0);
        end else begin
          acc_t a;
          a = exp_acc.pop_front();
          chk("acc_cycle", 64'(cyc), 64'(a.cyc));
          chk("acc_we", 64'(bus.ram_we_o), 64'(a.we));
          chk("acc_addr", 64'(bus.ram_addr_o), 64'(a.addr));
          chk("acc_be", 64'(bus.ram_be_o), 64'h0F);
          if (a.we) chk("acc_wdata", 64'(bus.ram_wdata_o), 64'(a.data));
        end
      end
      if (done_o) begin
        if (exp_done.size() == 0) begin
          chk("done_unexpected", 64'(done_o), 64'd0);
        end else begin
          done_t d;
          d = exp_done.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d.cyc));
          chk("done_busy", 64'(busy_o), 64'd1);
          chk("done_error", 64'(error_o), 64'(d.err));
          if (d.ea_chk) chk("done_err_addr", 64'(err_addr_o), 64'(d.ea));
        end
      end
      if (!bus.ram_en_o && !done_o && exp_acc.size() == 0 && exp_done.size() == 0)
        chk("busy_idle", 64'(busy_o), 64'd0);
    end
  end

  // Reference model: expected accesses and completion derived from the command
  task automatic issue(input logic [AW-1:0] base, input int n, input logic [DW-1:0] pat,
                       input bit incr, input bit ver, input int hold, output int t0);
    logic [AW-1:0] b;
    logic [AW-1:0] a;
    done_t         d;
    for (int i = 0; i < NWORDS; i++) corrupt[i] = 1'b0;
    b = {base[AW-1:2], 2'b00};
    foreach (cor_q[i]) corrupt[13'((int'(b) / 4 + cor_q[i]) % NWORDS)] = 1'b1;
    @(negedge clk);
    t0          = cyc;
    base_addr_i = base;
    num_words_i = (AW-1)'(n);
    pattern_i   = pat;
    incr_i      = incr;
    verify_i    = ver;
    start_i     = 1'b1;
    d.err = 1'b0;
    d.ea  = '0;
    d.ea_chk = (n != 0);
    for (int k = 0; k < n; k++) begin
      a = AW'((int'(b) + 4 * k) % 32768);
      exp_acc.push_back('{t0 + 1 + k, 1'b1, a, pat + (incr ? DW'(k) : DW'(0))});
    end
    if (ver) begin
      for (int k = 0; k < n; k++) begin
        a = AW'((int'(b) + 4 * k) % 32768);
        exp_acc.push_back('{t0 + 1 + n + k, 1'b0, a, '0});
        if (corrupt[a[AW-1:2]] && !d.err) begin
          d.err = 1'b1;
          d.ea  = a;
        end
      end
    end
    d.cyc = (n == 0) ? t0 + 1 : (ver ? t0 + 2 * n + 2 : t0 + n + 1);
    exp_done.push_back(d);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (h + 1 < hold) begin
        base_addr_i = AW'($urandom);
        num_words_i = (AW-1)'($urandom_range(1, 5));
        pattern_i   = $urandom;
        incr_i      = 1'($urandom);
        verify_i    = 1'($urandom);
      end
    end
    start_i = 1'b0;
    cor_q.delete();
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((exp_acc.size() != 0 || exp_done.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_acc.size() != 0 || exp_done.size() != 0) begin
      chk({nm, "_timeout"}, 64'(exp_acc.size() + exp_done.size()), 64'd0);
      exp_acc.delete();
      exp_done.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_busy"}, 64'(busy_o), 64'd0);
    chk({nm, "_done"}, 64'(done_o), 64'd0);
    chk({nm, "_error"}, 64'(error_o), 64'd0);
    chk({nm, "_err_addr"}, 64'(err_addr_o), 64'd0);
    chk({nm, "_ram_en"}, 64'(bus.ram_en_o), 64'd0);
    chk({nm, "_ram_we"}, 64'(bus.ram_we_o), 64'd0);
    chk({nm, "_ram_addr"}, 64'(bus.ram_addr_o), 64'd0);
    chk({nm, "_ram_wdata"}, 64'(bus.ram_wdata_o), 64'd0);
    chk({nm, "_ram_be"}, 64'(bus.ram_be_o), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_i = 1'b0;
    repeat (2) @(negedge clk);

    issue(15'h0100, 4, 32'hDEADBEEF, 1'b0, 1'b0, 1, t0);
    wait_idle("const_fill");

    issue(15'h0000, 8, 32'hFFFFFFFE, 1'b1, 1'b1, 1, t0);
    wait_idle("incr_verify");

    cor_q.push_back(5);
    cor_q.push_back(6);
    issue(15'h0000, 8, 32'hFFFFFFFE, 1'b1, 1'b1, 1, t0);
    wait_idle("fault");

    issue(15'h0040, 0, 32'h1, 1'b0, 1'b1, 1, t0);
    wait_idle("n_zero");

    issue(15'h7FF8, 4, 32'hA5A5_0000, 1'b1, 1'b1, 1, t0);
    wait_idle("wrap");

    issue(15'h0333, 6, 32'h0BAD_F00D, 1'b1, 1'b0, 5, t0);
    wait_idle("held_start");

    issue(15'h0200, 10, 32'h1234_0000, 1'b1, 1'b1, 1, t0);
    while (cyc < t0 + 3) @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    exp_acc.delete();
    exp_done.delete();
    check_all_zero("midfill_reset");
    @(negedge clk) rst_i = 1'b0;
    repeat (2) @(negedge clk);
    issue(15'h0200, 10, 32'h1234_0000, 1'b1, 1'b1, 1, t0);
    wait_idle("after_reset");

    for (int r = 0; r < 25; r++) begin
      int n;
      bit ver;
      n   = $urandom_range(0, 20);
      ver = 1'($urandom);
      if (ver && n > 0 && $urandom_range(0, 1) == 1) begin
        cor_q.push_back($urandom_range(0, n - 1));
        if ($urandom_range(0, 1) == 1) cor_q.push_back($urandom_range(0, n - 1));
      end
      issue(AW'($urandom), n, $urandom, 1'($urandom), ver, 1, t0);
      wait_idle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
